// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter: AES InvSubBytes over a 128-bit state, LANES bytes per cycle through a shared buffer.
module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int GROUPS = 16 / LANES;
  localparam int CW = GROUPS > 1 ? $clog2(GROUPS) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [127:0] buffer, sub;
  logic [CW-1:0] cnt;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] t;
    t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction
  always_comb begin
    sub = buffer;
    for (int l = 0; l < LANES; l++)
      sub[(int'(cnt) * LANES + l) * 8 +: 8] = inv_sbox(buffer[(int'(cnt) * LANES + l) * 8 +: 8]);
  end
  assign out_state = buffer;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      buffer    <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          buffer   <= in_state;
          cnt      <= '0;
          state    <= BUSY;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
        BUSY: begin
          buffer <= sub;
          if (cnt == CW'(GROUPS - 1)) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb_inv_sub_bytes_iter: vector table, random blocks against a table-inversion model, and handshake corner cases for LANES 1/2/4/16.
module tb_inv_sub_bytes_iter;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, out_ready = 1'b0;
  logic [3:0] iv = '0, ir, ov, bz;
  logic [127:0] din = '0;
  logic [127:0] os [4];
  int vectors = 0, miscompares = 0;
  int groups [4] = '{16, 8, 4, 1};
  logic [7:0] isb [256];
  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
    string        name;
  } vec_t;
  vec_t tbl [4];
  always #5 clk = ~clk;
  inv_sub_bytes_iter #(.LANES(1)) u1 (.clk(clk), .rst(rst), .clear(clear), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_state(din), .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]), .busy(bz[0]));
  inv_sub_bytes_iter #(.LANES(2)) u2 (.clk(clk), .rst(rst), .clear(clear), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_state(din), .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]), .busy(bz[1]));
  inv_sub_bytes_iter #(.LANES(4)) u4 (.clk(clk), .rst(rst), .clear(clear), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_state(din), .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]), .busy(bz[2]));
  inv_sub_bytes_iter #(.LANES(16)) u16 (.clk(clk), .rst(rst), .clear(clear), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_state(din), .out_valid(ov[3]), .out_ready(out_ready), .out_state(os[3]), .busy(bz[3]));
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ((int'(a) << i));
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h11b << (i - 8));
    return 8'(p);
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] w = {b, b};
    return w[15 - n -: 8];
  endfunction
  // inverse S-box obtained by inverting the forward S-box table
  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v = 8'h00, s;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      s = v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
      isb[s] = 8'(x);
    end
  endtask
  function automatic logic [127:0] model(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = isb[d[i*8 +: 8]];
    return r;
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int k, input logic [127:0] d);
    din = d;
    iv[k] = 1'b1;
    tick();
    iv[k] = 1'b0;
    din = ~d;
  endtask
  task automatic wait_done(input int k, input string name);
    int lat = 0;
    while (!ov[k] && lat < 40) begin
      tick();
      lat++;
    end
    check({name, " latency"}, 128'(lat), 128'(groups[k]));
  endtask
  task automatic release_out(input int k, input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " ready/valid after drain"}, {126'd0, ir[k], ov[k]}, 128'b10);
  endtask
  task automatic run_block(input int k, input logic [127:0] d, input logic [127:0] e, input string name);
    send(k, d);
    wait_done(k, name);
    check({name, " data"}, os[k], e);
    release_out(k, name);
  endtask
  initial begin
    logic [127:0] held, r;
    build_model();
    tbl[0] = '{{16{8'h00}}, {16{8'h52}}, "zeros"};
    tbl[1] = '{128'h0f0e0d0c0b0a09080706050403020100, 128'hfbd7f3819ea340bf38a53630d56a0952, "ramp"};
    tbl[2] = '{{16{8'hff}}, {16{8'h7d}}, "ones"};
    tbl[3] = '{{16{8'h63}}, {16{8'h00}}, "x63"};
    #12;
    check("reset out_state", os[2], '0);
    check("reset flags", {125'd0, ir[2], ov[2], bz[2]}, 128'b100);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 4; k++)
      for (int v = 0; v < 4; v++) run_block(k, tbl[v].din, tbl[v].dout, $sformatf("L%0d %s", k, tbl[v].name));
    for (int k = 0; k < 4; k++)
      for (int n = 0; n < 12; n++) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        run_block(k, r, model(r), $sformatf("L%0d rand%0d", k, n));
      end
    send(2, {16{8'h63}});
    wait_done(2, "hold");
    held = os[2];
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("hold cycle %0d", c), {ov[2], ir[2], os[2]}, {1'b1, 1'b0, 128'd0});
    end
    check("hold stable", os[2], held);
    release_out(2, "hold");
    send(2, {$urandom, $urandom, $urandom, $urandom});
    tick();
    #3 rst = 1'b1;
    #1;
    check("async reset state", os[2], '0);
    check("async reset flags", {125'd0, ir[2], ov[2], bz[2]}, 128'b100);
    @(negedge clk);
    rst = 1'b0;
    tick();
    run_block(2, {16{8'hff}}, {16{8'h7d}}, "after reset");
    clear = 1'b1;
    din = {16{8'h11}};
    iv[2] = 1'b1;
    tick();
    clear = 1'b0;
    iv[2] = 1'b0;
    check("clear beats valid", {126'd0, bz[2], ir[2]}, 128'b01);
    tick();
    check("clear beats valid later", {126'd0, bz[2], ov[2]}, 128'b00);
    send(2, {16{8'h00}});
    wait_done(2, "clear in done");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear in done", {125'd0, ov[2], bz[2], ir[2]}, 128'b001);
    run_block(2, tbl[1].din, tbl[1].dout, "after clear");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/inv_sub_bytes_iter.md
Name: inv_sub_bytes_iter

Overview:
- Iterative InvSubBytes stage of the AES decryption datapath.
- Accepts one 128-bit state from upstream InvShiftRows over a valid/ready handshake.
- Substitutes all 16 bytes through LANES instances of the inverse S-box, LANES bytes per cycle, then presents the result to the downstream AddRoundKey stage.
- Trades throughput for area against a fully parallel 16-S-box implementation.

Parameters:
- LANES, 4, inverse S-box instances / bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
- GROUPS, 16/LANES, derived localparam; BUSY cycles per block; never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- clear  in  1  synchronous abort; returns block to IDLE.
- in_valid  in  1  upstream has a state on in_state.
- in_ready  out  1  block can accept a state.
- in_state  in  128  input state; byte i = in_state[8i+7:8i], i=0..15.
- out_valid  out  1  out_state holds a completed result.
- out_ready  in  1  downstream accepts out_state.
- out_state  out  128  substituted state, same byte mapping as in_state.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; buffer=0; group counter=0.
  - out_state=0, out_valid=0, busy=0, in_ready=1 while in IDLE after reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready&&!clear: capture in_state into the 128-bit buffer, counter=0, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, bytes counter*LANES .. counter*LANES+LANES-1 of the buffer are replaced in place by their inverse S-box values; counter increments.
  - On the cycle processing group GROUPS-1: counter wraps to 0 and the FSM goes to DONE.
- DONE:
  - out_valid=1; out_state=buffer, held stable while out_ready=0 (no bubbles, no changes).
  - On out_valid&&out_ready: go to IDLE, out_valid=0 next cycle.
  - No new input is accepted in DONE (in_ready=0).
- Latency: handshake accepted at edge E -> out_valid=1 after edge E+GROUPS (LANES=4: 4 cycles).
- Minimum block interval: GROUPS+2 cycles.
- Combinational path: the inverse S-box lookup sits only between the buffer and the buffer write; out_state is driven directly from the buffer register.
- clear:
  - In any state, clear=1 forces IDLE next edge, counter=0, out_valid=0.
  - Buffer contents are don't-care after clear.
  - clear && in_valid in IDLE: clear wins; the input is not accepted and in_ready stays 1.
- rst asserted mid-BUSY or in DONE: immediate return to reset values; the partial result is discarded.
- in_state changes while not handshaked: ignored.
- Changes on in_state after acceptance do not affect the result.
- Every byte is substituted exactly once per block; no byte is skipped or repeated for any LANES value.

Test Plan:
- After reset, apply in_state = all bytes 0x00 with in_valid=1 -> out_valid after 4 cycles (LANES=4); out_state = all bytes 0x52.
- Apply in_state with byte i = i (0x00..0x0f) -> out_state bytes 0..15 = 52 09 6a d5 30 36 a5 38 bf 40 a3 9e 81 f3 d7 fb.
- Apply all bytes 0x63, then hold out_ready=0 for 10 cycles -> out_state = all 0x00 stays stable and out_valid=1 throughout; with out_ready=1 -> IDLE, in_ready=1 the next cycle.
- Assert rst during the 2nd BUSY cycle, then send all bytes 0xff -> outputs return to 0 asynchronously; the new block yields all bytes 0x7d, with no residue from the aborted block.
- Assert clear and in_valid together in IDLE -> block not accepted, busy=0; assert clear in DONE -> out_valid=0 next cycle.
- Repeat the first two scenarios with LANES=1, 2, 16 -> identical results; out_valid after 16, 8 and 1 cycles respectively.
